// File: rtl/mem_arbiter_ctrl_if.sv
// Bus bundle between the arbiter, the two L1 cache controllers and the
// physical memory port. The master modport is the arbiter's view. The slave
// modport is the environment's view (both caches and the memory model).
//
// Handshake: a cache raises *_pmem_read / dcache_pmem_write as a level and
// holds it until its one-cycle *_mem_resp, then drops it the following cycle.
// The arbiter raises pmem_read / pmem_write as a level and holds it, with a
// stable address and data, until memory returns a one-cycle pmem_resp.
// pmem_rdata is valid in the pmem_resp cycle only.
interface mem_arbiter_ctrl_if;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_mem_rdata;
  logic         icache_mem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_mem_rdata;
  logic         dcache_mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    input  icache_pmem_read, icache_pmem_address,
    output icache_mem_rdata, icache_mem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_mem_rdata, dcache_mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    output icache_pmem_read, icache_pmem_address,
    input  icache_mem_rdata, icache_mem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_mem_rdata, dcache_mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Physical-memory arbiter for the split L1 icache/dcache. One transaction at a
// time: arbitrate in IDLE, latch the request, run it on the pmem port from the
// latched copy, then pulse the requester's resp from a DONE state. The dcache
// has priority, but after DCACHE_BURST_MAX consecutive dcache grants with the
// icache waiting, the icache is served. All outputs come from flops or from a
// decode of the state register, so there is no input-to-output path.
module mem_arbiter_ctrl #(
  parameter int unsigned DCACHE_BURST_MAX = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_ctrl_if.master  bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  localparam logic [2:0] BURST_MAX = 3'(DCACHE_BURST_MAX);

  state_t       state_q, state_d;
  logic [2:0]   burst_cnt_q, burst_cnt_d;
  logic [15:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic         is_write_q, is_write_d;
  logic [127:0] i_rdata_q, i_rdata_d;
  logic [127:0] d_rdata_q, d_rdata_d;
  logic         i_req, d_req, grant_d, grant_i;

  // State and latched-request registers; reset clears everything visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= 3'd0;
      addr_q      <= 16'd0;
      wdata_q     <= 128'd0;
      is_write_q  <= 1'b0;
      i_rdata_q   <= 128'd0;
      d_rdata_q   <= 128'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state: arbitration in IDLE only; BUSY waits for pmem_resp; DONE lasts one cycle.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_req       = bus.icache_pmem_read;
    d_req       = bus.dcache_pmem_read | bus.dcache_pmem_write;
    // The dcache wins unless the icache has waited through a full burst.
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = d_req && (!i_req || (burst_cnt_q != BURST_MAX));
        grant_i = i_req && !grant_d;
        if (grant_d) begin
          state_d    = D_BUSY;
          addr_d     = bus.dcache_pmem_address;
          // Read and write together is illegal; treat it as a write-back.
          is_write_d = bus.dcache_pmem_write;
          if (bus.dcache_pmem_write) wdata_d = bus.dcache_pmem_wdata;
          if (i_req) begin
            if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + 3'd1;
          end else begin
            burst_cnt_d = 3'd0;
          end
        end else if (grant_i) begin
          state_d     = I_BUSY;
          addr_d      = bus.icache_pmem_address;
          is_write_d  = 1'b0;
          burst_cnt_d = 3'd0;
        end
      end
      I_BUSY: begin
        if (bus.pmem_resp) begin
          i_rdata_d = bus.pmem_rdata;
          state_d   = I_DONE;
        end
      end
      D_BUSY: begin
        if (bus.pmem_resp) begin
          // Write-back completions leave the dcache read block untouched.
          if (!is_write_q) d_rdata_d = bus.pmem_rdata;
          state_d = D_DONE;
        end
      end
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and latched registers only.
  assign bus.pmem_read        = (state_q == I_BUSY) || ((state_q == D_BUSY) && !is_write_q);
  assign bus.pmem_write       = (state_q == D_BUSY) && is_write_q;
  assign bus.pmem_address     = addr_q;
  assign bus.pmem_wdata       = wdata_q;
  assign bus.icache_mem_resp  = (state_q == I_DONE);
  assign bus.dcache_mem_resp  = (state_q == D_DONE);
  assign bus.icache_mem_rdata = i_rdata_q;
  assign bus.dcache_mem_rdata = d_rdata_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: a table of single transactions with
// hand-computed results, then hand-written sequences for dcache/icache
// interleaving, a request dropped mid-transaction, and reset during D_BUSY.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_mem_arbiter_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;
  logic [15:0] exp_q[$];

  mem_arbiter_ctrl_if bus();

  mem_arbiter_ctrl #(.DCACHE_BURST_MAX(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  localparam logic [2:0] S_IDLE = 3'd0;

  localparam logic [127:0] C_I1   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] C_D1   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C_I2   = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
  localparam logic [127:0] C_D2   = 128'h13579BDF2468ACE013579BDF2468ACE0;
  localparam logic [127:0] C_JUNK = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           lat;
    logic [127:0] mem_data;
    logic         exp_read;
    logic         exp_write;
    logic         exp_i_resp;
    logic         exp_d_resp;
    logic [127:0] exp_i_rdata;
    logic [127:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[5];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.icache_pmem_read    = 1'b0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
  endtask

  // Drive one table entry as a single transaction and act as the memory.
  task automatic run_vec(input int idx, input vec_t v);
    int strobe_cnt;
    strobe_cnt = 0;
    bus.icache_pmem_read    = v.i_rd;
    bus.icache_pmem_address = v.addr;
    bus.dcache_pmem_read    = v.d_rd;
    bus.dcache_pmem_write   = v.d_wr;
    bus.dcache_pmem_address = v.addr;
    bus.dcache_pmem_wdata   = v.wdata;
    for (int cyc = 1; cyc <= v.lat + 2; cyc++) begin
      tick();
      if (cyc <= v.lat) begin
        check($sformatf("v%0d_c%0d_pmem_read", idx, cyc), 128'(bus.pmem_read), 128'(v.exp_read));
        check($sformatf("v%0d_c%0d_pmem_write", idx, cyc), 128'(bus.pmem_write), 128'(v.exp_write));
        check($sformatf("v%0d_c%0d_pmem_address", idx, cyc), 128'(bus.pmem_address), 128'(v.addr));
        if (v.exp_write)
          check($sformatf("v%0d_c%0d_pmem_wdata", idx, cyc), bus.pmem_wdata, v.wdata);
        if (bus.pmem_read || bus.pmem_write) strobe_cnt++;
        if (cyc == v.lat) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = v.mem_data;
        end
      end else if (cyc == v.lat + 1) begin
        bus.pmem_resp = 1'b0;
        check($sformatf("v%0d_icache_resp", idx), 128'(bus.icache_mem_resp), 128'(v.exp_i_resp));
        check($sformatf("v%0d_dcache_resp", idx), 128'(bus.dcache_mem_resp), 128'(v.exp_d_resp));
        check($sformatf("v%0d_strobe_off", idx), 128'(bus.pmem_read | bus.pmem_write), 128'(0));
        drive_idle();
      end else begin
        check($sformatf("v%0d_state_idle", idx), 128'(dbg_state), 128'(S_IDLE));
        check($sformatf("v%0d_resp_off", idx),
              128'(bus.icache_mem_resp | bus.dcache_mem_resp), 128'(0));
        check($sformatf("v%0d_icache_rdata", idx), bus.icache_mem_rdata, v.exp_i_rdata);
        check($sformatf("v%0d_dcache_rdata", idx), bus.dcache_mem_rdata, v.exp_d_rdata);
      end
    end
    check($sformatf("v%0d_strobe_cycles", idx), 128'(strobe_cnt), 128'(v.lat));
  endtask

  initial begin
    int grants;
    int budget;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_idle();
    bus.icache_pmem_address = 16'd0;
    bus.dcache_pmem_address = 16'd0;
    bus.dcache_pmem_wdata   = 128'd0;
    bus.pmem_rdata          = 128'd0;
    bus.pmem_resp           = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 128'd0,          3, C_I1,
                1'b1, 1'b0, 1'b1, 1'b0, C_I1, 128'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h4440, {16{8'hA5}},     2, C_JUNK,
                1'b0, 1'b1, 1'b0, 1'b1, C_I1, 128'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h2000, 128'd0,          1, C_D1,
                1'b1, 1'b0, 1'b0, 1'b1, C_I1, C_D1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h3330, {16{8'h5A}},     4, C_JUNK,
                1'b0, 1'b1, 1'b0, 1'b1, C_I1, C_D1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0FF0, 128'd0,          1, C_I2,
                1'b1, 1'b0, 1'b1, 1'b0, C_I2, C_D1};

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_state", 128'(dbg_state), 128'(S_IDLE));
    check("rst_pmem_read", 128'(bus.pmem_read), 128'(0));
    check("rst_pmem_write", 128'(bus.pmem_write), 128'(0));
    check("rst_pmem_address", 128'(bus.pmem_address), 128'(0));
    check("rst_pmem_wdata", bus.pmem_wdata, 128'd0);
    check("rst_resps", 128'(bus.icache_mem_resp | bus.dcache_mem_resp), 128'(0));
    check("rst_i_rdata", bus.icache_mem_rdata, 128'd0);
    check("rst_d_rdata", bus.dcache_mem_rdata, 128'd0);

    // Table of single transactions
    for (int i = 0; i < 5; i++) begin
      run_vec(i, vecs[i]);
      tick();
    end

    // Both caches request continuously: expect D, D, I, D, D, I.
    exp_q.push_back(16'hD000);
    exp_q.push_back(16'hD000);
    exp_q.push_back(16'h1000);
    exp_q.push_back(16'hD000);
    exp_q.push_back(16'hD000);
    exp_q.push_back(16'h1000);
    bus.icache_pmem_address = 16'h1000;
    bus.dcache_pmem_address = 16'hD000;
    bus.icache_pmem_read    = 1'b1;
    bus.dcache_pmem_read    = 1'b1;
    grants = 0;
    budget = 0;
    while (grants < 6 && budget < 60) begin
      tick();
      budget++;
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        grants++;
        if (exp_q.size() > 0)
          check($sformatf("order_grant%0d", grants), 128'(bus.pmem_address), 128'(exp_q.pop_front()));
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {4{32'($urandom_range(0, 32'hFFFF))}};
        if (grants == 6) drive_idle();
      end
    end
    check("order_grant_count", 128'(grants), 128'(6));
    tick();
    bus.pmem_resp = 1'b0;
    drive_idle();
    repeat (3) tick();
    check("order_back_idle", 128'(dbg_state), 128'(S_IDLE));

    // dcache drops its read and changes its address mid-transaction.
    bus.dcache_pmem_address = 16'h5550;
    bus.dcache_pmem_read    = 1'b1;
    tick();
    check("drop_c1_read", 128'(bus.pmem_read), 128'(1));
    check("drop_c1_addr", 128'(bus.pmem_address), 128'(16'h5550));
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_address = 16'h6660;
    for (int c = 2; c <= 3; c++) begin
      tick();
      check($sformatf("drop_c%0d_read", c), 128'(bus.pmem_read), 128'(1));
      check($sformatf("drop_c%0d_addr", c), 128'(bus.pmem_address), 128'(16'h5550));
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = C_D2;
    tick();
    bus.pmem_resp = 1'b0;
    check("drop_dcache_resp", 128'(bus.dcache_mem_resp), 128'(1));
    check("drop_dcache_rdata", bus.dcache_mem_rdata, C_D2);
    tick();
    check("drop_idle", 128'(dbg_state), 128'(S_IDLE));

    // Reset during D_BUSY, then a stale pmem_resp.
    bus.dcache_pmem_address = 16'h7770;
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_wdata   = {16{8'h3C}};
    tick();
    check("rstbusy_write", 128'(bus.pmem_write), 128'(1));
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;
    check("rstbusy_state", 128'(dbg_state), 128'(S_IDLE));
    check("rstbusy_strobes", 128'(bus.pmem_read | bus.pmem_write), 128'(0));
    check("rstbusy_address", 128'(bus.pmem_address), 128'(0));
    check("rstbusy_wdata", bus.pmem_wdata, 128'd0);
    check("rstbusy_d_rdata", bus.dcache_mem_rdata, 128'd0);
    check("rstbusy_i_rdata", bus.icache_mem_rdata, 128'd0);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = C_JUNK;
    tick();
    bus.pmem_resp = 1'b0;
    tick();
    check("stale_resps", 128'(bus.icache_mem_resp | bus.dcache_mem_resp), 128'(0));
    check("stale_state", 128'(dbg_state), 128'(S_IDLE));
    check("stale_d_rdata", bus.dcache_mem_rdata, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Sequenced physical-memory arbiter between the split L1 instruction and data caches of the pipelined LC-3b core. It owns the single physical memory port, grants it to one cache at a time through an explicit state machine, and latches each granted request for its whole transaction. Priority goes to the dcache, with a bounded-starvation guarantee for the icache. It sits between the two cache controllers and the pmem model or L2.

## Interface
- DCACHE_BURST_MAX, default 2: maximum consecutive dcache grants while an icache request is pending. Legal range is 1..7.
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous and active-high
- icache_pmem_read  in  1  icache read request; level, held until icache_mem_resp
- icache_pmem_address  in  16  icache block address (lc3b_word)
- icache_mem_rdata  out  128  read block returned to the icache (lc3b_block)
- icache_mem_resp  out  1  one-cycle completion pulse to the icache
- dcache_pmem_read  in  1  dcache read request; level
- dcache_pmem_write  in  1  dcache write-back request; level
- dcache_pmem_address  in  16  dcache block address
- dcache_pmem_wdata  in  128  dcache write-back block
- dcache_mem_rdata  out  128  read block returned to the dcache
- dcache_mem_resp  out  1  one-cycle completion pulse to the dcache
- pmem_read  out  1  memory read strobe; level, held until pmem_resp
- pmem_write  out  1  memory write strobe; level, held until pmem_resp
- pmem_address  out  16  memory address
- pmem_wdata  out  128  memory write block
- pmem_rdata  in  128  memory read block; valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle

## Operation
- States are IDLE, I_BUSY, D_BUSY, I_DONE and D_DONE.
- IDLE, arbitration:
  - Neither request pending: stay in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant the dcache unless burst_cnt == DCACHE_BURST_MAX, in which case grant the icache.
- On a grant, latch the address. For a dcache write, also latch wdata and an is_write flag.
- dcache_pmem_read and dcache_pmem_write both high is illegal. The write wins: is_write=1.
- I_BUSY / D_BUSY:
  - Drive pmem_read or pmem_write plus pmem_address and pmem_wdata from the latched registers only. Live request inputs are ignored.
  - On pmem_resp, capture pmem_rdata into the requester's rdata register and move to the matching *_DONE state.
  - Dropping the request mid-transaction does not abort it.
- I_DONE / D_DONE:
  - Assert the matching *_mem_resp for exactly one cycle. pmem strobes are low.
  - Return to IDLE next cycle. No arbitration happens in a DONE cycle.
- burst_cnt is a 3-bit counter:
  - Increments on each dcache grant while icache_pmem_read is high.
  - Clears on any icache grant.
  - Clears on any dcache grant while icache_pmem_read is low.
  - Saturates at DCACHE_BURST_MAX.
- *_mem_rdata holds its last captured value until the next capture for that cache. dcache write completions do not update dcache_mem_rdata.

## Timing
- Reset values:
  - state=IDLE, burst_cnt=0.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - icache_mem_resp=0, dcache_mem_resp=0, icache_mem_rdata=0, dcache_mem_rdata=0.
- Reset mid-transaction drops the pmem strobes on the next cycle. The memory side must abandon the access.
- All outputs are registered or decoded from state and latched registers. There is no combinational path from inputs to outputs.
- Latency, with a request sampled in IDLE at edge 0:
  - The pmem strobe is high from cycle 1.
  - pmem_resp arrives in cycle N.
  - *_mem_resp is high in cycle N+1.
  - The state is IDLE in cycle N+2.
  - Minimum request-to-resp latency is 2 cycles, when pmem_resp comes in cycle 1.
- pmem_resp outside BUSY states is ignored.
- A requester must deassert in the cycle after its resp. A request still high in IDLE is treated as a new request.
- Back-to-back service: the second grant is sampled in IDLE at cycle N+2, so its pmem strobe rises at cycle N+3.

## Test plan
- Single icache read at 0x1230, memory returns 0x0123…EF after 3 cycles:
  - pmem_read is high for exactly 3 cycles with pmem_address=0x1230.
  - icache_mem_resp pulses once with that data.
  - dcache_mem_resp stays 0.
- dcache write-back at 0x4440, wdata 0xA5 repeated:
  - pmem_write=1 with that address and data until pmem_resp.
  - dcache_mem_resp pulses once.
  - dcache_mem_rdata is unchanged.
- Both caches request continuously with DCACHE_BURST_MAX=2: grant order is D, D, I, D, D, I.
- Request dropped mid-transaction: dcache deasserts its read 1 cycle after the grant, and the dcache changes its address input during the transaction.
  - pmem_read and the latched address stay stable until pmem_resp.
  - dcache_mem_resp still pulses.
- Reset asserted during D_BUSY:
  - Next cycle, all outputs are 0 and state is IDLE.
  - A stale pmem_resp arriving afterwards produces no *_mem_resp.
- Both dcache read and write asserted: pmem_write=1 and pmem_read=0 for the entire transaction.
